shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Iterative sequencer for the 16-bit logarithmic shifter used by the execute stage.
- Applies one power-of-two stage (1, 2, 4, 8) per clock instead of all four combinationally, so the shift is off the single-cycle critical path.
- Supports ROL, SLL, ROR and SRL.
- Uses a valid/ready handshake on input and output, a pipeline-flush kill input, and optional early exit when the remaining count bits are zero.

Parameters:
- WIDTH, 16, data width; must equal 2**CNT_W.
- CNT_W, 4, shift-count width; also the number of shifter stages.
- EARLY_EXIT, 1, 1 = finish once the remaining count bits are zero; 0 = always run CNT_W stage cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- kill  input  1  synchronous flush; aborts any operation in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- In  input  WIDTH  operand.
- Cnt  input  CNT_W  shift amount, 0..WIDTH-1.
- Op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Out  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, any state): state=IDLE, Out=0, out_valid=0, stage index k=0, captured registers cleared; in_ready=1, busy=0 immediately.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready and busy are decoded from state only. Request acceptance never depends combinationally on out_ready.
- Accept (IDLE, in_valid=1): capture In into the data register, and capture Cnt and Op; set k=0.
  - Cnt==0: go to DONE with Out=In.
  - Otherwise: go to SHIFT.
- SHIFT, each cycle:
  - If cnt_reg[k]=1, apply a shift of 2**k per Op.
    - ROL/ROR: bits wrap around.
    - SLL: zero fill from the LSB side.
    - SRL: zero fill from the MSB side.
  - If cnt_reg[k]=0, data passes unchanged.
  - Exit to DONE when k==CNT_W-1, or when EARLY_EXIT=1 and cnt_reg[CNT_W-1:k+1]==0. Otherwise k=k+1.
- Latency, counting edges from the accept edge to the edge that sets out_valid:
  - Cnt==0: 1.
  - Otherwise with EARLY_EXIT=1: 1 + (index of highest set Cnt bit + 1).
  - Otherwise with EARLY_EXIT=0: 1 + CNT_W.
  - Examples with EARLY_EXIT=1: Cnt=1 gives 2, Cnt=4 gives 4, Cnt=15 gives 5.
- DONE:
  - Out and out_valid hold stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE and drop out_valid.
  - No new request is accepted in that same cycle; the minimum issue interval is latency+1.
- Out is registered and holds its last value in IDLE.
- kill=1 (SHIFT or DONE): next state IDLE, out_valid=0, result discarded.
  - kill in IDLE with in_valid=1: the request is not accepted.
  - kill has priority over every other transition.
- Changes on In, Cnt or Op after acceptance have no effect.
- Cnt values are interpreted modulo WIDTH by construction. No illegal Op encodings exist.

Test Plan:
- SLL In=0x00F1 Cnt=4, out_ready=1 -> Out=0x0F10; out_valid rises 4 edges after accept, stays high 1 cycle.
- ROL In=0x8001 Cnt=1 -> Out=0x0003 at latency 2. ROR In=0x1234 Cnt=8 -> Out=0x3412 at latency 5.
- SRL In=0x8000 Cnt=15 -> Out=0x0001 at latency 5. ROR In=0x0001 Cnt=0 -> Out=0x0001 at latency 1.
- Backpressure: SLL In=0x0001 Cnt=3, out_ready=0 for 3 cycles after out_valid.
  - Required: Out=0x0008 held, in_ready=0, busy=1 throughout.
  - Handshake then returns to IDLE with in_ready=1 the next cycle.
- kill asserted in the 2nd SHIFT cycle of SRL 0xFFFF Cnt=12:
  - Required: out_valid never rises, in_ready=1 after the next edge.
  - A following SLL 0x0003 Cnt=2 gives 0x000C.
- rst pulsed mid-SHIFT, between clock edges:
  - Required: in_ready=1, out_valid=0, Out=0x0000, busy=0 immediately without a clock edge.
  - Repeat with EARLY_EXIT=0: Cnt=1 takes latency 5.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Iterative sequencer for the execute-stage logarithmic
//                shifter. One power-of-two stage (1, 2, 4, 8, ...) is applied
//                per clock, which keeps the shift off the single-cycle
//                critical path. Supports ROL, SLL, ROR and SRL. Uses a
//                valid/ready handshake on both sides, a flush (kill) input,
//                and optional early exit once the remaining count bits are
//                all zero.
//                WIDTH is expected to equal 2**CNT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    // Width of the stage index (0 .. CNT_W-1)
    localparam int K_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [1:0] c_OP_ROL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_ROR = 2'b10;
    localparam logic [1:0] c_OP_SRL = 2'b11;

    localparam logic [CNT_W:0] c_AMT_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] c_AMT_FULL = (CNT_W+1)'(WIDTH);
    localparam logic [K_W-1:0] c_K_LAST   = K_W'(CNT_W - 1);
    localparam logic [K_W:0]   c_K_ONE    = (K_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;      // working operand, one stage applied per cycle
    logic [CNT_W-1:0] r_cnt;       // captured shift amount
    logic [1:0]       r_op;        // captured operation
    logic [K_W-1:0]   r_k;         // current stage index
    logic [WIDTH-1:0] r_out;       // result register, only updated on completion
    logic             r_outValid;

    logic [CNT_W:0]   w_amt;       // 2**k
    logic [CNT_W:0]   w_amtInv;    // WIDTH - 2**k, the wrap-around part of a rotate
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_stageOut;
    logic [K_W:0]     w_kNext;
    logic             w_upperZero;
    logic             w_lastStage;

    assign w_amt    = c_AMT_ONE << r_k;
    assign w_amtInv = c_AMT_FULL - w_amt;

    // Single shifter stage of size 2**k selected by the captured operation
    always_comb begin
        w_shifted = r_data;
        case (r_op)
            c_OP_ROL: w_shifted = (r_data << w_amt) | (r_data >> w_amtInv);
            c_OP_SLL: w_shifted = r_data << w_amt;
            c_OP_ROR: w_shifted = (r_data >> w_amt) | (r_data << w_amtInv);
            c_OP_SRL: w_shifted = r_data >> w_amt;
            default:  w_shifted = r_data;
        endcase
    end

    assign w_stageOut  = r_cnt[r_k] ? w_shifted : r_data;

    // Early exit: no count bits above the current stage remain set
    assign w_kNext     = {1'b0, r_k} + c_K_ONE;
    assign w_upperZero = ((r_cnt >> w_kNext) == '0);
    assign w_lastStage = (r_k == c_K_LAST) || ((EARLY_EXIT != 0) && w_upperZero);

    // Sequencer FSM: accept, iterate stages, hold result until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_k        <= '0;
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (kill) begin
            // Flush wins over everything; a request offered in IDLE is dropped
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
            r_k        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= In;
                        r_cnt  <= Cnt;
                        r_op   <= Op;
                        r_k    <= '0;
                        if (Cnt == '0) begin
                            r_out      <= In;
                            r_outValid <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= w_stageOut;
                    if (w_lastStage) begin
                        r_out      <= w_stageOut;
                        r_outValid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake status is a pure decode of the state register
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_outValid;
    assign Out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl. Instance A uses
//                early exit, instance B always runs every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        inValidA = 1'b0;
    logic        inValidB = 1'b0;
    logic        outReady = 1'b1;
    logic [15:0] In = '0;
    logic [3:0]  Cnt = '0;
    logic [1:0]  Op = '0;

    logic        inReadyA, outValidA, busyA;
    logic [15:0] outA;
    logic        inReadyB, outValidB, busyB;
    logic [15:0] outB;

    bit          selB = 1'b0;
    logic        curInReady, curOutValid, curBusy;
    logic [15:0] curOut;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(16), .CNT_W(4), .EARLY_EXIT(1)) dutA (
        .clk(clk), .rst(rst), .kill(kill),
        .in_valid(inValidA), .in_ready(inReadyA),
        .In(In), .Cnt(Cnt), .Op(Op),
        .out_valid(outValidA), .out_ready(outReady),
        .Out(outA), .busy(busyA)
    );

    shift_seq_ctrl #(.WIDTH(16), .CNT_W(4), .EARLY_EXIT(0)) dutB (
        .clk(clk), .rst(rst), .kill(kill),
        .in_valid(inValidB), .in_ready(inReadyB),
        .In(In), .Cnt(Cnt), .Op(Op),
        .out_valid(outValidB), .out_ready(outReady),
        .Out(outB), .busy(busyB)
    );

    assign curInReady  = selB ? inReadyB  : inReadyA;
    assign curOutValid = selB ? outValidB : outValidA;
    assign curBusy     = selB ? busyB     : busyA;
    assign curOut      = selB ? outB      : outA;

    typedef struct {
        bit          useB;
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        int          stall;
        logic [15:0] expOut;
        int          expLat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from the arithmetic definition of each operation
    function automatic logic [15:0] refShift(input logic [1:0] op, input logic [15:0] x, input int c);
        int unsigned v;
        int unsigned r;
        v = x;
        case (op)
            2'd0:    r = ((v << c) | (v >> (16 - c))) & 32'hFFFF;
            2'd1:    r = (v << c) & 32'hFFFF;
            2'd2:    r = ((v >> c) | (v << (16 - c))) & 32'hFFFF;
            default: r = v >> c;
        endcase
        return r[15:0];
    endfunction

    // Reference latency: edges from accept to out_valid
    function automatic int refLat(input int c, input bit early);
        int hi;
        if (c == 0) return 1;
        if (!early) return 1 + 4;
        hi = 0;
        for (int b = 0; b < 4; b++) if (((c >> b) & 1) != 0) hi = b;
        return 1 + hi + 1;
    endfunction

    // Issue one request, measure latency, apply backpressure, complete handshake
    task automatic runOp(input bit useB, input logic [1:0] op, input logic [15:0] din,
                         input logic [3:0] cnt, input int stall,
                         input logic [15:0] expOut, input int expLat, input string tag);
        int lat;
        selB = useB;
        @(negedge clk);
        check({tag, " in_ready before issue"}, curInReady, 1);
        outReady = (stall == 0);
        In = din; Cnt = cnt; Op = op;
        if (useB) inValidB = 1'b1; else inValidA = 1'b1;
        @(negedge clk);
        inValidA = 1'b0; inValidB = 1'b0;
        In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
        lat = 1;
        while (!curOutValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, expLat);
        check({tag, " Out"}, curOut, expOut);
        for (int i = 0; i < stall; i++) begin
            check({tag, " held Out"}, curOut, expOut);
            check({tag, " held in_ready"}, curInReady, 0);
            check({tag, " held busy"}, curBusy, 1);
            @(negedge clk);
        end
        check({tag, " out_valid before handshake"}, curOutValid, 1);
        outReady = 1'b1;
        @(negedge clk);
        check({tag, " out_valid after handshake"}, curOutValid, 0);
        check({tag, " in_ready after handshake"}, curInReady, 1);
        check({tag, " busy after handshake"}, curBusy, 0);
        check({tag, " Out held in IDLE"}, curOut, expOut);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd1, 16'h00F1, 4'd4,  0, 16'h0F10, 4};
        vecs[1] = '{1'b0, 2'd0, 16'h8001, 4'd1,  0, 16'h0003, 2};
        vecs[2] = '{1'b0, 2'd2, 16'h1234, 4'd8,  0, 16'h3412, 5};
        vecs[3] = '{1'b0, 2'd3, 16'h8000, 4'd15, 0, 16'h0001, 5};
        vecs[4] = '{1'b0, 2'd2, 16'h0001, 4'd0,  0, 16'h0001, 1};
        vecs[5] = '{1'b0, 2'd1, 16'h0001, 4'd3,  3, 16'h0008, 3};
        vecs[6] = '{1'b1, 2'd0, 16'h8001, 4'd1,  0, 16'h0003, 5};
        vecs[7] = '{1'b1, 2'd3, 16'h8000, 4'd15, 0, 16'h0001, 5};

        // Reset state
        #12;
        check("reset in_ready", inReadyA, 1);
        check("reset out_valid", outValidA, 0);
        check("reset Out", outA, 16'h0000);
        check("reset busy", busyA, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++)
            runOp(vecs[i].useB, vecs[i].op, vecs[i].din, vecs[i].cnt, vecs[i].stall,
                  vecs[i].expOut, vecs[i].expLat, $sformatf("vec%0d", i));

        // kill during the second SHIFT cycle of SRL 0xFFFF >> 12
        selB = 1'b0;
        @(negedge clk);
        In = 16'hFFFF; Cnt = 4'd12; Op = 2'd3; inValidA = 1'b1; outReady = 1'b1;
        @(negedge clk);
        inValidA = 1'b0;
        check("kill first SHIFT busy", busyA, 1);
        @(negedge clk);
        check("kill second SHIFT out_valid", outValidA, 0);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill in_ready", inReadyA, 1);
        check("kill busy", busyA, 0);
        for (int i = 0; i < 6; i++) begin
            check("kill out_valid stays low", outValidA, 0);
            @(negedge clk);
        end
        runOp(1'b0, 2'd1, 16'h0003, 4'd2, 0, 16'h000C, 3, "postkill");

        // kill in IDLE blocks acceptance
        @(negedge clk);
        kill = 1'b1; inValidA = 1'b1; In = 16'h0005; Cnt = 4'd1; Op = 2'd1;
        @(negedge clk);
        kill = 1'b0; inValidA = 1'b0;
        check("idle kill in_ready", inReadyA, 1);
        check("idle kill busy", busyA, 0);
        @(negedge clk);
        check("idle kill out_valid", outValidA, 0);

        // kill while holding a result in DONE
        @(negedge clk);
        outReady = 1'b0; In = 16'h00FF; Cnt = 4'd0; Op = 2'd0; inValidA = 1'b1;
        @(negedge clk);
        inValidA = 1'b0;
        check("done kill pre out_valid", outValidA, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0; outReady = 1'b1;
        check("done kill out_valid", outValidA, 0);
        check("done kill in_ready", inReadyA, 1);

        // Asynchronous reset between clock edges while both instances shift
        @(negedge clk);
        In = 16'h0001; Cnt = 4'd8; Op = 2'd1; inValidA = 1'b1; inValidB = 1'b1;
        @(negedge clk);
        inValidA = 1'b0; inValidB = 1'b0;
        check("pre-reset busy A", busyA, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready A", inReadyA, 1);
        check("async rst out_valid A", outValidA, 0);
        check("async rst Out A", outA, 16'h0000);
        check("async rst busy A", busyA, 0);
        check("async rst in_ready B", inReadyB, 1);
        check("async rst busy B", busyB, 0);
        #1 rst = 1'b0;
        runOp(1'b1, 2'd0, 16'h8001, 4'd1, 0, 16'h0003, 5, "postrst B");

        // Randomised operations against the reference model
        for (int i = 0; i < 60; i++) begin
            bit          ub;
            logic [1:0]  op;
            logic [15:0] d;
            logic [3:0]  c;
            ub = ($urandom_range(0, 3) == 0);
            op = 2'($urandom);
            d  = 16'($urandom);
            c  = 4'($urandom);
            runOp(ub, op, d, c, $urandom_range(0, 2), refShift(op, d, int'(c)),
                  refLat(int'(c), !ub), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
